mem_arbiter: RTL and testbench

Shares the single external memory bus between the CPU and one DMA-style requester, such as a video or serial engine. It inserts a programmable number of wait states per access and drives the CPU's n_mem_rdy input. It also selects the address/strobe source and times the memory strobes. On contention it arbitrates round-robin, and it caps DMA bursts so the CPU cannot be starved.

---
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one external memory bus between the CPU and a single
// DMA-style requester (video / serial engine).
//
// Every access lasts WAIT_STATES+1 cycles. The grant decision is taken in IDLE
// and in the final cycle of each access, so back-to-back accesses run with no
// idle bubble. Contention is resolved round-robin. A DMA burst is capped at
// DMA_MAX_BURST accesses while the CPU is waiting.
//
// Ports
//   clk, n_rst          : clock, asynchronous active-low reset
//   cpu_req/we/addr     : CPU request; held until n_mem_rdy is seen low
//   n_mem_rdy           : low for the final cycle of a CPU access
//   dma_req/we/addr     : DMA request; held until dma_ack is seen high
//   dma_gnt             : high while the DMA owns the bus
//   dma_ack             : high for the final cycle of a DMA access
//   mem_addr            : memory address (0 when idle)
//   n_mem_oe, n_mem_we  : active-low memory strobes
//   mem_sel_dma         : data-bus mux select, 1 = DMA side
module mem_arbiter #(
    parameter int ADDR_WIDTH    = 16,
    parameter int WAIT_STATES   = 1,
    parameter int DMA_MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    output logic                  n_mem_rdy,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    output logic                  dma_gnt,
    output logic                  dma_ack,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  n_mem_oe,
    output logic                  n_mem_we,
    output logic                  mem_sel_dma
);

    localparam logic [2:0] WS_INIT   = 3'(WAIT_STATES);
    localparam logic [3:0] BURST_CAP = 4'(DMA_MAX_BURST - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CPU  = 2'd1,
        ST_DMA  = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] wait_cnt_q, wait_cnt_d;
    logic [3:0] burst_cnt_q, burst_cnt_d;
    logic       last_dma_q, last_dma_d;   // 1 = DMA had the most recent grant

    logic final_cyc;
    logic decide;
    logic dma_keep;

    assign final_cyc = (wait_cnt_q == 3'd0);
    assign decide    = (state_q == ST_IDLE) || final_cyc;
    // DMA may continue its burst over a waiting CPU until the cap is reached.
    assign dma_keep  = (state_q == ST_DMA) && dma_req && cpu_req &&
                       (burst_cnt_q < BURST_CAP);

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        burst_cnt_d = burst_cnt_q;
        last_dma_d  = last_dma_q;

        if (wait_cnt_q != 3'd0) wait_cnt_d = wait_cnt_q - 3'd1;

        if (decide) begin
            // Round-robin: with both requesting, DMA wins only if the CPU
            // had the previous grant.
            if (dma_keep || (dma_req && (!cpu_req || !last_dma_q)))
                state_d = ST_DMA;
            else if (cpu_req)
                state_d = ST_CPU;
            else
                state_d = ST_IDLE;

            if (state_d != ST_IDLE) begin
                wait_cnt_d = WS_INIT;
                last_dma_d = (state_d == ST_DMA);
            end

            if (state_d == ST_DMA && state_q == ST_DMA) begin
                if (burst_cnt_q < BURST_CAP) burst_cnt_d = burst_cnt_q + 4'd1;
            end else if (state_d != ST_DMA) begin
                burst_cnt_d = 4'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= 3'd0;
            burst_cnt_q <= 4'd0;
            last_dma_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            last_dma_q  <= last_dma_d;
        end
    end

    // Outputs decode straight from the registered state. The write strobe is
    // held off until the final cycle to give WAIT_STATES cycles of setup.
    always_comb begin
        mem_addr    = '0;
        n_mem_oe    = 1'b1;
        n_mem_we    = 1'b1;
        n_mem_rdy   = 1'b1;
        dma_gnt     = 1'b0;
        dma_ack     = 1'b0;
        mem_sel_dma = 1'b0;
        case (state_q)
            ST_CPU: begin
                mem_addr  = cpu_addr;
                n_mem_oe  = cpu_we;
                n_mem_we  = !(cpu_we && final_cyc);
                n_mem_rdy = !final_cyc;
            end
            ST_DMA: begin
                mem_addr    = dma_addr;
                n_mem_oe    = dma_we;
                n_mem_we    = !(dma_we && final_cyc);
                dma_gnt     = 1'b1;
                dma_ack     = final_cyc;
                mem_sel_dma = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Two instances share the stimulus:
//   u_dut : WAIT_STATES=1, DMA_MAX_BURST=4
//   u_rr  : WAIT_STATES=0, DMA_MAX_BURST=1 (one-cycle accesses, pure alternation)
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
    logic [15:0] cpu_addr = '0, dma_addr = '0;

    logic        m_rdy, m_gnt, m_ack, m_oe, m_we, m_sel;
    logic [15:0] m_addr;
    logic        r_rdy, r_gnt, r_ack, r_oe, r_we, r_sel;
    logic [15:0] r_addr;

    int n_cmp = 0;
    int n_fail = 0;
    logic which = 1'b0;  // 0 = observe u_dut, 1 = observe u_rr

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(16), .WAIT_STATES(1), .DMA_MAX_BURST(4)) u_dut (
        .clk(clk), .n_rst(n_rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .n_mem_rdy(m_rdy),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_gnt(m_gnt), .dma_ack(m_ack), .mem_addr(m_addr),
        .n_mem_oe(m_oe), .n_mem_we(m_we), .mem_sel_dma(m_sel)
    );

    mem_arbiter #(.ADDR_WIDTH(16), .WAIT_STATES(0), .DMA_MAX_BURST(1)) u_rr (
        .clk(clk), .n_rst(n_rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .n_mem_rdy(r_rdy),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_gnt(r_gnt), .dma_ack(r_ack), .mem_addr(r_addr),
        .n_mem_oe(r_oe), .n_mem_we(r_we), .mem_sel_dma(r_sel)
    );

    typedef struct {
        logic        cr, cw;
        logic [15:0] ca;
        logic        dr, dw;
        logic [15:0] da;
        logic [21:0] exp;
    } vec_t;

    // Output bundle: {n_mem_rdy, dma_gnt, dma_ack, n_mem_oe, n_mem_we, mem_sel_dma, mem_addr}
    function automatic logic [21:0] mk(input logic rdy, gnt, ack, oe, we, sel,
                                       input logic [15:0] addr);
        return {rdy, gnt, ack, oe, we, sel, addr};
    endfunction

    function automatic logic [21:0] m_pack();
        return {m_rdy, m_gnt, m_ack, m_oe, m_we, m_sel, m_addr};
    endfunction

    function automatic vec_t vec(input logic cr, cw, input logic [15:0] ca,
                                 input logic dr, dw, input logic [15:0] da,
                                 input logic [21:0] exp);
        vec_t v;
        v.cr = cr; v.cw = cw; v.ca = ca; v.dr = dr; v.dw = dw; v.da = da; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_s(input string name, input string act, input string exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_all();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0;
    endtask

    task automatic do_reset();
        drop_all();
        n_rst = 0;
        #1;
        chk("reset_state", 32'(m_pack()), 32'(mk(1, 0, 0, 1, 1, 0, 16'h0)));
        cyc();
        n_rst = 1;
        #1;
    endtask

    // Record completion pulses ("C" = n_mem_rdy low, "D" = dma_ack high) on
    // the selected instance until n events are seen or the budget runs out.
    // Counts cycles with no owner once the bus has been granted (all
    // addresses used with this task are nonzero).
    task automatic collect(input int n, input int budget, output string s, output int bubbles);
        logic rdy, ack, gnt, started;
        logic [15:0] addr;
        s = "";
        bubbles = 0;
        started = 0;
        for (int c = 0; c < budget; c++) begin
            #1;
            rdy  = which ? r_rdy  : m_rdy;
            ack  = which ? r_ack  : m_ack;
            gnt  = which ? r_gnt  : m_gnt;
            addr = which ? r_addr : m_addr;
            if (gnt || addr != 16'h0) started = 1;
            else if (started) bubbles++;
            if (!rdy) s = {s, "C"};
            if (ack)  s = {s, "D"};
            if (s.len() >= n) break;
            @(posedge clk);
        end
    endtask

    vec_t tbl[13];
    string ev;
    int bub;

    initial begin
        tbl[0]  = vec(0, 0, 16'h0000, 0, 0, 16'h0000, mk(1, 0, 0, 1, 1, 0, 16'h0000));
        tbl[1]  = vec(1, 0, 16'h1234, 0, 0, 16'h0000, mk(1, 0, 0, 1, 1, 0, 16'h0000));
        tbl[2]  = vec(1, 0, 16'h1234, 0, 0, 16'h0000, mk(1, 0, 0, 0, 1, 0, 16'h1234));
        tbl[3]  = vec(0, 0, 16'h1234, 0, 0, 16'h0000, mk(0, 0, 0, 0, 1, 0, 16'h1234));
        tbl[4]  = vec(0, 0, 16'h0000, 0, 0, 16'h0000, mk(1, 0, 0, 1, 1, 0, 16'h0000));
        tbl[5]  = vec(0, 0, 16'h0000, 1, 1, 16'hBEEF, mk(1, 0, 0, 1, 1, 0, 16'h0000));
        tbl[6]  = vec(0, 0, 16'h0000, 1, 1, 16'hBEEF, mk(1, 1, 0, 1, 1, 1, 16'hBEEF));
        tbl[7]  = vec(0, 0, 16'h0000, 0, 1, 16'hBEEF, mk(1, 1, 1, 1, 0, 1, 16'hBEEF));
        tbl[8]  = vec(0, 0, 16'h0000, 0, 0, 16'h0000, mk(1, 0, 0, 1, 1, 0, 16'h0000));
        tbl[9]  = vec(1, 1, 16'h00FF, 0, 0, 16'h0000, mk(1, 0, 0, 1, 1, 0, 16'h0000));
        tbl[10] = vec(1, 1, 16'h00FF, 0, 0, 16'h0000, mk(1, 0, 0, 1, 1, 0, 16'h00FF));
        tbl[11] = vec(0, 1, 16'h00FF, 0, 0, 16'h0000, mk(0, 0, 0, 1, 0, 0, 16'h00FF));
        tbl[12] = vec(0, 0, 16'h0000, 0, 0, 16'h0000, mk(1, 0, 0, 1, 1, 0, 16'h0000));

        // Single accesses: CPU read, DMA write, CPU write.
        do_reset();
        which = 0;
        for (int i = 0; i < 13; i++) begin
            cpu_req = tbl[i].cr; cpu_we = tbl[i].cw; cpu_addr = tbl[i].ca;
            dma_req = tbl[i].dr; dma_we = tbl[i].dw; dma_addr = tbl[i].da;
            #1;
            chk($sformatf("vec%0d", i), 32'(m_pack()), 32'(tbl[i].exp));
            cyc();
        end

        // Both requesting from reset: CPU first, then a capped DMA burst.
        do_reset();
        cpu_req = 1; cpu_addr = 16'h1111;
        dma_req = 1; dma_addr = 16'h2222;
        collect(6, 40, ev, bub);
        chk_s("contend_order", ev, "CDDDDC");
        chk("contend_bubbles", 32'(bub), 32'd0);

        // DMA streaming, CPU arrives during access 1: four acks, then CPU.
        do_reset();
        dma_req = 1; dma_addr = 16'h3333;
        cyc();
        cpu_req = 1; cpu_addr = 16'h4444;
        collect(5, 40, ev, bub);
        chk_s("burst_cap_order", ev, "DDDDC");
        chk("burst_cap_bubbles", 32'(bub), 32'd0);

        // Single-cycle accesses, no burst allowance: strict alternation.
        do_reset();
        which = 1;
        cpu_req = 1; cpu_addr = 16'h0101;
        dma_req = 1; dma_addr = 16'h0202;
        collect(6, 30, ev, bub);
        chk_s("rr_alternate", ev, "CDCDCD");
        chk("rr_bubbles", 32'(bub), 32'd0);

        // Single-cycle CPU writes back to back: rdy and we low every cycle.
        do_reset();
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0042;
        cyc();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("ws0_rdy_we%0d", i), {30'd0, r_rdy, r_we}, 32'd0);
            cyc();
        end
        which = 0;

        // Reset in the wait cycle of a DMA read aborts it with no ack.
        do_reset();
        dma_req = 1; dma_addr = 16'h3333;
        cyc();
        chk("pre_abort_gnt_ack", {30'd0, m_gnt, m_ack}, 32'b10);
        #2;
        n_rst = 0;
        #1;
        chk("abort_outputs", 32'(m_pack()), 32'(mk(1, 0, 0, 1, 1, 0, 16'h0)));
        dma_req = 0;
        cyc();
        chk("abort_no_ack", {30'd0, m_gnt, m_ack}, 32'd0);
        #2;
        n_rst = 1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h5555;
        collect(1, 10, ev, bub);
        chk_s("post_reset_cpu", ev, "C");
        chk("post_reset_addr", 32'(m_addr), 32'h5555);
        drop_all();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
